// File: rtl/wb_port_arb_if.sv
// Bundle of the writeback-stage, memory-response and register-file write signals
// that the port arbiter carries. master = pipeline/memory side, slave = arbiter.
interface wb_port_arb_if;
  logic        pipe_valid;
  logic        pipe_we;
  logic [1:0]  pipe_wb_sel;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_alu;
  logic [31:0] pipe_pc4;
  logic        pipe_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;
  logic        protocol_err;

  modport master (
    output pipe_valid, pipe_we, pipe_wb_sel, pipe_rd, pipe_alu, pipe_pc4,
    output mem_rvalid, mem_rdata,
    input  pipe_ready, rf_we, rf_waddr, rf_wdata, pending_mask, protocol_err
  );

  modport slave (
    input  pipe_valid, pipe_we, pipe_wb_sel, pipe_rd, pipe_alu, pipe_pc4,
    input  mem_rvalid, mem_rdata,
    output pipe_ready, rf_we, rf_waddr, rf_wdata, pending_mask, protocol_err
  );
endinterface

// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: shares one write port between in-order
// pipeline results and returning load data, tracks outstanding loads in an
// in-order queue, and stalls on structural and WAW hazards.
module wb_port_arb #(
  parameter int LQ_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  wb_port_arb_if.slave bus
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic [4:0]       lq_mem [LQ_DEPTH];
  logic [PTR_W-1:0] lq_rd_ptr;
  logic [PTR_W-1:0] lq_wr_ptr;
  logic [CNT_W-1:0] lq_count;
  logic [4:0]       lq_head;

  logic             skid_valid;
  logic [4:0]       skid_addr;
  logic [31:0]      skid_data;

  logic [31:0]      pending_q;
  logic             err_q;
  logic             rf_we_q;
  logic [4:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q;

  logic             waw_hit;
  logic             ready;
  logic             accept;
  logic             do_load;
  logic             do_direct;
  logic             mem_pop;
  logic             mem_orphan;
  logic [31:0]      direct_data;
  logic [31:0]      mask_set;
  logic [31:0]      mask_clr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign lq_head = lq_mem[lq_rd_ptr];

  // Accept decode, hazard stall and pending-mask set/clear vectors.
  always_comb begin
    waw_hit     = bus.pipe_we && (bus.pipe_wb_sel != 2'b11) && pending_q[bus.pipe_rd];
    ready       = !skid_valid && (lq_count < CNT_W'(LQ_DEPTH)) && !waw_hit;
    accept      = bus.pipe_valid && ready;
    do_load     = accept && bus.pipe_we && (bus.pipe_wb_sel == 2'b00);
    do_direct   = accept && bus.pipe_we && (bus.pipe_wb_sel == 2'b01 || bus.pipe_wb_sel == 2'b10)
                  && (bus.pipe_rd != 5'd0);
    mem_pop     = bus.mem_rvalid && (lq_count != '0);
    mem_orphan  = bus.mem_rvalid && (lq_count == '0);
    direct_data = (bus.pipe_wb_sel == 2'b10) ? bus.pipe_pc4 : bus.pipe_alu;
    mask_set    = '0;
    mask_clr    = '0;
    if (do_load && bus.pipe_rd != 5'd0) mask_set[bus.pipe_rd] = 1'b1;
    if (mem_pop) mask_clr[lq_head] = 1'b1;
  end

  // Load-queue storage; entries need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (do_load) lq_mem[lq_wr_ptr] <= bus.pipe_rd;
  end

  // Queue pointers/count, scoreboard, sticky error flag and skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lq_rd_ptr  <= '0;
      lq_wr_ptr  <= '0;
      lq_count   <= '0;
      pending_q  <= '0;
      err_q      <= 1'b0;
      skid_valid <= 1'b0;
      skid_addr  <= '0;
      skid_data  <= '0;
    end else begin
      if (do_load) lq_wr_ptr <= ptr_inc(lq_wr_ptr);
      if (mem_pop) lq_rd_ptr <= ptr_inc(lq_rd_ptr);
      lq_count  <= lq_count + CNT_W'(do_load) - CNT_W'(mem_pop);
      pending_q <= (pending_q & ~mask_clr) | mask_set;
      if (mem_orphan) err_q <= 1'b1;
      if (bus.mem_rvalid && do_direct) begin
        skid_valid <= 1'b1;
        skid_addr  <= bus.pipe_rd;
        skid_data  <= direct_data;
      end else if (!bus.mem_rvalid) begin
        skid_valid <= 1'b0;
      end
    end
  end

  // Write port: memory response beats the skid, which beats a fresh direct write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      if (bus.mem_rvalid) begin
        if (mem_pop) begin
          rf_we_q    <= (lq_head != 5'd0);
          rf_waddr_q <= lq_head;
          rf_wdata_q <= bus.mem_rdata;
        end
      end else if (skid_valid) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= skid_addr;
        rf_wdata_q <= skid_data;
      end else if (do_direct) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= bus.pipe_rd;
        rf_wdata_q <= direct_data;
      end
    end
  end

  assign bus.pipe_ready   = ready;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.pending_mask = pending_q;
  assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_wb_port_arb.sv
// Bench for wb_port_arb: directed vectors push expected register-file writes
// (address, data, cycle) into a scoreboard; a negedge monitor pops and compares.
module tb_wb_port_arb;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  wb_port_arb_if bus_if();

  wb_port_arb #(.LQ_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp used to pin each expected write to its cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic drv(input logic v, input logic we, input logic [1:0] sel, input logic [4:0] rd,
                     input logic [31:0] alu, input logic [31:0] pc4);
    bus_if.pipe_valid  = v;
    bus_if.pipe_we     = we;
    bus_if.pipe_wb_sel = sel;
    bus_if.pipe_rd     = rd;
    bus_if.pipe_alu    = alu;
    bus_if.pipe_pc4    = pc4;
  endtask

  task automatic mem(input logic v, input logic [31:0] d);
    bus_if.mem_rvalid = v;
    bus_if.mem_rdata  = d;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 2'b11, 5'd0, 32'h0, 32'h0);
    mem(1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] rd);
    drv(1'b1, 1'b1, 2'b00, rd, 32'h0, 32'h0);
  endtask

  // Monitor: every rf_we pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus_if.rf_we) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got x%0d=0x%08h at cycle %0d, want no write",
                 bus_if.rf_waddr, bus_if.rf_wdata, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus_if.rf_waddr !== e.addr || bus_if.rf_wdata !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL rf_write: got x%0d=0x%08h at cycle %0d, want x%0d=0x%08h at cycle %0d",
                   bus_if.rf_waddr, bus_if.rf_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rf_we", bus_if.rf_we, 0);
    chk("reset_rf_waddr", bus_if.rf_waddr, 0);
    chk("reset_rf_wdata", bus_if.rf_wdata, 0);
    chk("reset_mask", bus_if.pending_mask, 0);
    chk("reset_err", bus_if.protocol_err, 0);
    chk("reset_ready", bus_if.pipe_ready, 1);
    step();
    rst = 1'b0;
    step();

    // Direct writes on consecutive cycles.
    drv(1'b1, 1'b1, 2'b01, 5'd5, 32'h1234, 32'h0);
    expect_wr(5'd5, 32'h1234, cyc + 1);
    @(negedge clk); chk("dir_alu_ready", bus_if.pipe_ready, 1);
    step();
    drv(1'b1, 1'b1, 2'b10, 5'd1, 32'h0, 32'h100);
    expect_wr(5'd1, 32'h100, cyc + 1);
    @(negedge clk); chk("dir_pc4_ready", bus_if.pipe_ready, 1);
    step(); idle();
    step();

    // Load to x7, data three cycles later.
    load(5'd7);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        mem(1'b1, 32'hDEADBEEF);
        expect_wr(5'd7, 32'hDEADBEEF, cyc + 1);
      end
      @(negedge clk); chk("ld_mask_pending", bus_if.pending_mask, 32'h80);
      step();
    end
    idle();
    @(negedge clk); chk("ld_mask_clear", bus_if.pending_mask, 0);
    step();

    // Memory response and direct write collide.
    load(5'd3);
    step();
    drv(1'b1, 1'b1, 2'b01, 5'd4, 32'hB, 32'h0);
    mem(1'b1, 32'hA);
    expect_wr(5'd3, 32'hA, cyc + 1);
    expect_wr(5'd4, 32'hB, cyc + 2);
    @(negedge clk); chk("cf_ready_in", bus_if.pipe_ready, 1);
    step(); idle();
    @(negedge clk); chk("cf_ready_skid", bus_if.pipe_ready, 0);
    step();
    @(negedge clk); chk("cf_ready_after", bus_if.pipe_ready, 1);
    step();

    // WAW: ALU write to x9 waits for the outstanding load to x9.
    load(5'd9);
    step();
    drv(1'b1, 1'b1, 2'b01, 5'd9, 32'h99, 32'h0);
    @(negedge clk); chk("waw_stall", bus_if.pipe_ready, 0);
    step();
    mem(1'b1, 32'h55);
    expect_wr(5'd9, 32'h55, cyc + 1);
    @(negedge clk); chk("waw_stall_resp", bus_if.pipe_ready, 0);
    step();
    mem(1'b0, 32'h0);
    expect_wr(5'd9, 32'h99, cyc + 1);
    @(negedge clk); chk("waw_release", bus_if.pipe_ready, 1);
    step(); idle();
    step();

    // Queue full, in-order responses, load to x0.
    load(5'd10);
    step();
    load(5'd11);
    @(negedge clk); chk("lq_second_ready", bus_if.pipe_ready, 1);
    step();
    load(5'd12);
    @(negedge clk);
    chk("lq_full_stall", bus_if.pipe_ready, 0);
    chk("lq_mask_two", bus_if.pending_mask, 32'h0000_0C00);
    mem(1'b1, 32'h1);
    expect_wr(5'd10, 32'h1, cyc + 1);
    step();
    mem(1'b1, 32'h2);
    expect_wr(5'd11, 32'h2, cyc + 1);
    @(negedge clk); chk("lq_slot_free", bus_if.pipe_ready, 1);
    step(); idle();
    @(negedge clk); chk("lq_mask_x12", bus_if.pending_mask, 32'h0000_1000);
    step();
    mem(1'b1, 32'h3);
    expect_wr(5'd12, 32'h3, cyc + 1);
    step(); idle();
    load(5'd0);
    step(); idle();
    @(negedge clk); chk("x0_mask", bus_if.pending_mask, 0);
    step();
    mem(1'b1, 32'h77);
    step(); idle();
    @(negedge clk); chk("x0_no_err", bus_if.protocol_err, 0);
    step();

    // Orphan response sets the sticky error.
    mem(1'b1, 32'h66);
    step(); idle();
    @(negedge clk); chk("err_set", bus_if.protocol_err, 1);
    step();
    @(negedge clk); chk("err_sticky", bus_if.protocol_err, 1);
    step();

    // Reset in the middle of an outstanding load.
    drv(1'b1, 1'b1, 2'b01, 5'd21, 32'h21, 32'h0);
    expect_wr(5'd21, 32'h21, cyc + 1);
    step();
    load(5'd20);
    step(); idle();
    @(negedge clk); chk("rst_mask_before", bus_if.pending_mask, 32'h0010_0000);
    #1 rst = 1'b1;
    #1;
    chk("rst_rf_we", bus_if.rf_we, 0);
    chk("rst_rf_waddr", bus_if.rf_waddr, 0);
    chk("rst_rf_wdata", bus_if.rf_wdata, 0);
    chk("rst_mask", bus_if.pending_mask, 0);
    chk("rst_err", bus_if.protocol_err, 0);
    chk("rst_ready", bus_if.pipe_ready, 1);
    step();
    rst = 1'b0;
    mem(1'b1, 32'h5);
    step(); idle();
    @(negedge clk); chk("rst_err_orphan", bus_if.protocol_err, 1);
    step();

    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arb.md
# wb_port_arb

Register-file write-port arbiter and writeback scheduler for the rv32 pipeline. The block sits after the writeback select decode, which produces `wb_sel`. It shares the single register-file write port between two sources: in-order pipeline results (ALU, PC+4) and out-of-order-in-time load data returning from memory. It tracks outstanding loads in an in-order queue and keeps a pending-destination scoreboard. It stalls the pipeline on structural and WAW hazards.

## Interface
- `LQ_DEPTH`, default 2: maximum outstanding loads; must be ≥1.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `pipe_valid`  in  1: a writeback-stage instruction is presented.
- `pipe_we`  in  1: the instruction writes rd.
- `pipe_wb_sel`  in  2: source select.
  - 00 = memory (load)
  - 01 = ALU
  - 10 = PC+4
  - 11 = no write
- `pipe_rd`  in  5: destination register.
- `pipe_alu`  in  32: ALU result.
- `pipe_pc4`  in  32: link value.
- `pipe_ready`  out  1: instruction accepted this cycle when `pipe_valid` is high.
- `mem_rvalid`  in  1: load data returns (1-cycle pulse, no backpressure).
- `mem_rdata`  in  32: load data.
- `rf_we`  out  1: register-file write enable (registered).
- `rf_waddr`  out  5: write address (registered).
- `rf_wdata`  out  32: write data (registered).
- `pending_mask`  out  32: bit r set while a load to xr is outstanding; bit 0 is always 0.
- `protocol_err`  out  1: sticky flag, `mem_rvalid` received with the load queue empty.

## Operation
- **Load:** `pipe_valid & pipe_we & pipe_wb_sel==00`.
  - On accept, push `pipe_rd` into the load queue, even if rd==0.
  - On accept, set `pending_mask[rd]` if rd≠0.
- **Direct write:** `pipe_valid & pipe_we & pipe_wb_sel∈{01,10} & pipe_rd≠0`.
  - Data is `pipe_alu` (01) or `pipe_pc4` (10).
- **Accepted with no effect:** `pipe_wb_sel==11`, `pipe_we==0`, or a direct write to rd==0.
- **`pipe_ready`** = `!skid_valid & (lq_count<LQ_DEPTH) & !(pipe_we & pipe_wb_sel!=11 & pending_mask[pipe_rd])`.
  - It is combinational on `pipe_rd`, `pipe_we` and `pipe_wb_sel`, and on registered state.
  - The WAW stall applies to loads and direct writes alike. This guarantees at most one outstanding load per rd, so the mask is exact.
- **Port priority each cycle:** memory response, then skid entry, then accepted direct write.
  - One write per cycle at most.
- **Memory response with queue non-empty:**
  - Pop the queue head.
  - Drive `rf_we<=(head≠0)`, `rf_waddr<=head`, `rf_wdata<=mem_rdata`.
  - Clear `pending_mask[head]`.
- **Memory response with queue empty:**
  - Discard the response.
  - Set `protocol_err`, which stays set until reset.
- **Skid register (1 entry):**
  - An accepted direct write that loses the port to a memory response is stored in the skid.
  - The skid drains on the next cycle without `mem_rvalid`.
  - No new instruction is accepted while the skid is full.
- **Load queue:** FIFO with wrapping pointers and count 0..`LQ_DEPTH`.
  - Push and pop in the same cycle are allowed at full.
  - However, no push occurs at full because `pipe_ready`=0.
- **Same-cycle set and clear of `pending_mask`** hit different bits; the WAW stall guarantees this.

## Timing
- **Reset values:**
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `pending_mask`=0, `protocol_err`=0.
  - Queue empty, skid empty.
  - `pipe_ready`=1 after reset.
- **Direct write** accepted at edge N with the port free: `rf_we`=1 during cycle N+1.
- **Memory response** at edge N: written during cycle N+1. The `pending_mask` bit drops at the same edge.
- **Conflict:** direct write and `mem_rvalid` at edge N.
  - Memory data is written in N+1.
  - The direct write goes to the skid and is written in the first cycle after the first edge ≥N+1 with no `mem_rvalid`.
  - `pipe_ready`=0 while the skid is full.
- **`rf_we` is a pulse:** 0 in any cycle with no write selected. `rf_waddr` and `rf_wdata` hold their last values.
- **Reset mid-operation:** outstanding loads are dropped and the mask is cleared. A later `mem_rvalid` sets `protocol_err`.

## Test plan
- **Direct writes:** ALU write x5=0x1234 (sel 01), then PC+4 write x1=0x100 (sel 10) → `rf_we` pulses with x5/0x1234 then x1/0x100 on consecutive cycles. `pipe_ready` stays 1.
- **Load and scoreboard:** load to x7; `mem_rvalid` 3 cycles later with 0xDEADBEEF → `pending_mask`=0x80 for 3 cycles, then x7 written with 0xDEADBEEF and the mask returns to 0.
- **Conflict:** `mem_rvalid` for pending x3 (data 0xA) in the same cycle an ALU write x4=0xB is accepted → x3/0xA in N+1, x4/0xB in N+2. `pipe_ready`=0 in N+1.
- **WAW stall:** load x9 outstanding, then an ALU write to x9 is presented → `pipe_ready`=0 until the load data is written. The ALU write is then accepted and lands after the load value.
- **Queue full and ordering:** `LQ_DEPTH`=2. Loads to x10 and x11, then a third load → the third load stalls. Responses 0x1 and 0x2 are written in order, x10 then x11. Load to x0 → queue pops, no `rf_we`.
- **Error and reset:** `mem_rvalid` with the queue empty → `protocol_err`=1 and no write. Assert `rst` mid-load → all outputs 0 and `pending_mask`=0.
